// File: rtl/score_keeper_pkg.sv
// Shared types and defaults for the score keeper: FSM states, winner codes,
// and default game constants.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } score_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;

  localparam int DEF_WIN_SCORE   = 5;
  localparam int DEF_HOLD_FRAMES = 60;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/score_keeper_if.sv
// Signal bundle between game logic / VGA sync and the score keeper, plus a
// debug view of the FSM state.
interface score_keeper_if #(
  parameter int CNT_W = 4
);
  import score_pkg::*;

  // No valid/ready here: start/point0/point1 are level signals whose rising
  // edge is one event; vsync is active-low and its falling edge marks a frame.
  logic               start;
  logic               point0;
  logic               point1;
  logic               vsync;
  logic               score0;
  logic               score1;
  logic [CNT_W-1:0]   count0;
  logic [CNT_W-1:0]   count1;
  logic [1:0]         winner;
  logic               game_over;
  score_state_t       state;

  modport master (
    output start, point0, point1, vsync,
    input  score0, score1, count0, count1, winner, game_over, state
  );

  modport slave (
    input  start, point0, point1, vsync,
    output score0, score1, count0, count1, winner, game_over, state
  );

endinterface

// File: rtl/score_keeper_sig_edge.sv
// One-bit sampling register with combinational rise/fall event outputs.
module sig_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RST_VAL;
    else      q <= d;
  end

  assign rise = d & ~q;
  assign fall = q & ~d;

endmodule

// File: rtl/score_keeper.sv
// Per-player score tracker with frame-timed display hold and winner detection.
// Optional build macro SCORE_BLINK_EN makes the held flag blink every 8 frames.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  score_keeper_if.slave  bus
);

  localparam int              FW     = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(WIN_SCORE);
  localparam logic [FW-1:0]    HOLD_C = FW'(HOLD_FRAMES);

  logic       start_ev, p0_ev, p1_ev, frame_ev;
  logic [3:0] fall_unused;
  logic       vsync_rise_unused;

  sig_edge #(.RST_VAL(1'b0)) u_start  (.clk(clk), .rst(rst), .d(bus.start),  .rise(start_ev), .fall(fall_unused[0]));
  sig_edge #(.RST_VAL(1'b0)) u_point0 (.clk(clk), .rst(rst), .d(bus.point0), .rise(p0_ev),    .fall(fall_unused[1]));
  sig_edge #(.RST_VAL(1'b0)) u_point1 (.clk(clk), .rst(rst), .d(bus.point1), .rise(p1_ev),    .fall(fall_unused[2]));
  // vsync idles high, so its register resets high to avoid a false frame.
  sig_edge #(.RST_VAL(1'b1)) u_vsync  (.clk(clk), .rst(rst), .d(bus.vsync),  .rise(vsync_rise_unused), .fall(frame_ev));
  assign fall_unused[3] = 1'b0;

  score_state_t     state, state_n;
  logic [CNT_W-1:0] count0, count0_n, count1, count1_n;
  logic             flag0, flag0_n, flag1, flag1_n;
  logic [1:0]       winner, winner_n;
  logic [FW-1:0]    frame_cnt, frame_cnt_n;
  logic             scorer, scorer_n;   // 0: player 0 owns the hold, 1: player 1
`ifdef SCORE_BLINK_EN
  logic [2:0]       blink_cnt, blink_cnt_n;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < WIN_C) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count0    <= '0;
      count1    <= '0;
      flag0     <= 1'b0;
      flag1     <= 1'b0;
      winner    <= WIN_NONE;
      frame_cnt <= '0;
      scorer    <= 1'b0;
`ifdef SCORE_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      count0    <= count0_n;
      count1    <= count1_n;
      flag0     <= flag0_n;
      flag1     <= flag1_n;
      winner    <= winner_n;
      frame_cnt <= frame_cnt_n;
      scorer    <= scorer_n;
`ifdef SCORE_BLINK_EN
      blink_cnt <= blink_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    count0_n    = count0;
    count1_n    = count1;
    flag0_n     = flag0;
    flag1_n     = flag1;
    winner_n    = winner;
    frame_cnt_n = frame_cnt;
    scorer_n    = scorer;
`ifdef SCORE_BLINK_EN
    blink_cnt_n = blink_cnt;
`endif
    case (state)
      IDLE: begin
        count0_n = '0;
        count1_n = '0;
        if (start_ev) state_n = PLAY;
      end
      PLAY: begin
        if (start_ev) begin
          count0_n = '0;
          count1_n = '0;
        end else if (p0_ev ^ p1_ev) begin
          // Simultaneous points cancel; only a lone point starts a hold.
          scorer_n    = p1_ev;
          frame_cnt_n = HOLD_C;
          state_n     = HOLD;
`ifdef SCORE_BLINK_EN
          blink_cnt_n = '0;
`endif
          if (p0_ev) begin
            count0_n = sat_inc(count0);
            flag0_n  = 1'b1;
          end else begin
            count1_n = sat_inc(count1);
            flag1_n  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (start_ev) begin
          count0_n = '0;
          count1_n = '0;
          flag0_n  = 1'b0;
          flag1_n  = 1'b0;
          state_n  = PLAY;
        end else if (frame_ev) begin
          if (frame_cnt <= FW'(1)) begin
            frame_cnt_n = '0;
            flag0_n     = 1'b0;
            flag1_n     = 1'b0;
            state_n     = PLAY;
            if (!scorer && count0 == WIN_C) begin
              winner_n = WIN_P0;
              flag0_n  = 1'b1;
              state_n  = OVER;
            end else if (scorer && count1 == WIN_C) begin
              winner_n = WIN_P1;
              flag1_n  = 1'b1;
              state_n  = OVER;
            end
          end else begin
            frame_cnt_n = frame_cnt - 1'b1;
`ifdef SCORE_BLINK_EN
            blink_cnt_n = blink_cnt + 1'b1;
            if (blink_cnt == 3'd7) begin
              if (scorer) flag1_n = ~flag1;
              else        flag0_n = ~flag0;
            end
`endif
          end
        end
      end
      OVER: begin
        if (start_ev) begin
          count0_n = '0;
          count1_n = '0;
          flag0_n  = 1'b0;
          flag1_n  = 1'b0;
          winner_n = WIN_NONE;
          state_n  = PLAY;
        end
      end
    endcase
  end

  assign bus.score0    = flag0;
  assign bus.score1    = flag1;
  assign bus.count0    = count0;
  assign bus.count1    = count1;
  assign bus.winner    = winner;
  assign bus.game_over = (state == OVER);
  assign bus.state     = state;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: WIN_SCORE=3, HOLD_FRAMES=2 (20 in the
// SCORE_BLINK_EN build), frames of 2 low + 18 high vsync cycles.
module tb_score_keeper;
  import score_pkg::*;

  localparam int WS = 3;
`ifdef SCORE_BLINK_EN
  localparam int HF = 20;
`else
  localparam int HF = 2;
`endif
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if #(.CNT_W(CW)) bus();

  score_keeper #(
    .WIN_SCORE(WS),
    .HOLD_FRAMES(HF),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          sample_pending = 1'b0;

  function automatic logic [15:0] pack(logic [1:0] st, logic [1:0] w, logic [3:0] c1,
                                       logic [3:0] c0, logic s1, logic s0, logic go);
    return {1'b0, st, w, c1, c0, s1, s0, go};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed {st,win,c1,c0,s1,s0,go}=%h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic [1:0] w,
                            input logic [3:0] c1, input logic [3:0] c0,
                            input logic s1, input logic s0, input logic go);
    exp_q.push_back(pack(st, w, c1, c0, s1, s0, go));
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [15:0] obs;
    if (exp_q.size() > 0) begin
      obs = pack(bus.state, bus.winner, bus.count1, bus.count0,
                 bus.score1, bus.score0, bus.game_over);
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (sample_pending) begin
      sample_pending = 1'b0;
      compare_out();
    end
  end

  // drivers: entered and left at posedge+1
  task automatic drive_pulse(input logic s, input logic p0, input logic p1);
    bus.start  = s;
    bus.point0 = p0;
    bus.point1 = p1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.point0 = 1'b0;
    bus.point1 = 1'b0;
    sample_pending = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_frame();
    bus.vsync = 1'b0;
    @(posedge clk); #1;
    sample_pending = 1'b1;
    @(posedge clk); #1;
    bus.vsync = 1'b1;
    repeat (18) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic blink_flag(int i);
`ifdef SCORE_BLINK_EN
    return ((i / 8) % 2) == 0;
`else
    return (i >= 0);
`endif
  endfunction

  // Runs a full hold; pl is the scoring player, over says whether it wins.
  task automatic run_hold(input string tag, input logic pl, input logic [3:0] c1,
                          input logic [3:0] c0, input logic over);
    for (int i = 1; i <= HF; i++) begin
      if (i < HF)
        expect_out({tag, "_frame"}, HOLD, WIN_NONE, c1, c0,
                   pl & blink_flag(i), ~pl & blink_flag(i), 1'b0);
      else if (over)
        expect_out({tag, "_over"}, OVER, pl ? WIN_P1 : WIN_P0, c1, c0, pl, ~pl, 1'b1);
      else
        expect_out({tag, "_exit"}, PLAY, WIN_NONE, c1, c0, 1'b0, 1'b0, 1'b0);
      do_frame();
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.point0 = 1'b0;
    bus.point1 = 1'b0;
    bus.vsync  = 1'b1;
    #2;
    expect_out("reset", IDLE, WIN_NONE, 0, 0, 0, 0, 0);
    compare_out();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    expect_out("p0_idle", IDLE, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(0, 1, 0);
    expect_out("start", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(1, 0, 0);
    expect_out("frame_play", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    do_frame();

    expect_out("p0_first", HOLD, WIN_NONE, 0, 1, 0, 1, 0);
    drive_pulse(0, 1, 0);
    expect_out("p1_in_hold", HOLD, WIN_NONE, 0, 1, 0, 1, 0);
    drive_pulse(0, 0, 1);
    run_hold("hold1", 1'b0, 0, 1, 1'b0);

    expect_out("both_points", PLAY, WIN_NONE, 0, 1, 0, 0, 0);
    drive_pulse(0, 1, 1);
    expect_out("p0_second", HOLD, WIN_NONE, 0, 2, 0, 1, 0);
    drive_pulse(0, 1, 0);

    // asynchronous reset mid-cycle during HOLD
    #2 rst = 1'b0;
    #1;
    expect_out("async_rst", IDLE, WIN_NONE, 0, 0, 0, 0, 0);
    compare_out();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    expect_out("p0_after_rst", IDLE, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(0, 1, 0);
    expect_out("restart", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(1, 0, 0);

    for (int k = 1; k <= WS; k++) begin
      expect_out("p1_score", HOLD, WIN_NONE, 4'(k), 0, 1, 0, 0);
      drive_pulse(0, 0, 1);
      run_hold("hold_p1", 1'b1, 4'(k), 0, k == WS);
    end
    expect_out("p1_in_over", OVER, WIN_P1, 3, 0, 1, 0, 1);
    drive_pulse(0, 0, 1);
    expect_out("frame_over", OVER, WIN_P1, 3, 0, 1, 0, 1);
    do_frame();
    expect_out("start_over", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(1, 0, 0);

    expect_out("p0_hold_a", HOLD, WIN_NONE, 0, 1, 0, 1, 0);
    drive_pulse(0, 1, 0);
    expect_out("start_hold", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(1, 0, 0);

    expect_out("p0_hold_b", HOLD, WIN_NONE, 0, 1, 0, 1, 0);
    drive_pulse(0, 1, 0);
    run_hold("hold_b", 1'b0, 0, 1, 1'b0);
    expect_out("start_play", PLAY, WIN_NONE, 0, 0, 0, 0, 0);
    drive_pulse(1, 0, 0);

    for (int k = 1; k <= WS; k++) begin
      expect_out("p0_score", HOLD, WIN_NONE, 0, 4'(k), 0, 1, 0);
      drive_pulse(0, 1, 0);
      run_hold("hold_p0", 1'b0, 0, 4'(k), k == WS);
    end
    expect_out("p0_in_over", OVER, WIN_P0, 0, 3, 0, 1, 1);
    drive_pulse(0, 1, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side score tracker and the stage directly upstream of the VGA top level.
- Counts points per player from game-logic pulses and detects the winner.
- Drives the 1-bit score0/score1 display flags that the VGA pixel generator consumes.
- Display-hold timing is measured in VGA frames, taken from vsync; runs entirely on the system clock.

Parameters:
- WIN_SCORE, 5: points needed to win; legal range 1..2^CNT_W-1.
- HOLD_FRAMES, 60: frames a score flag stays asserted after a point; minimum 1.
- CNT_W, 4: width of the per-player score counters.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin or restart a game; rising-edge detected.
- point0  in  1  player 0 scored; rising-edge detected.
- point1  in  1  player 1 scored; rising-edge detected.
- vsync  in  1  active-low frame sync from the VGA controller; sampled as data.
- score0  out  1  display flag for player 0.
- score1  out  1  display flag for player 1.
- count0  out  CNT_W  player 0 score.
- count1  out  CNT_W  player 1 score.
- winner  out  2  00 none, 01 player 0, 10 player 1.
- game_over  out  1  high in OVER.

Behaviour:
- Reset: rst low forces, immediately and asynchronously, FSM=IDLE and all outputs 0. Edge registers reset to 0; vsync register resets to 1. A reset mid-game discards all state.
- Edge detection: each of start, point0, point1 is registered once. A rising event = sig & ~sig_q. A frame event = vsync_q & ~vsync (falling edge of vsync).
- Latency: a detected event changes state and outputs at the same clock edge that samples it. Outputs are visible 1 cycle after the input is first sampled high.
- IDLE: counts held at 0. start event -> PLAY.
- PLAY, exactly one point event: that player's count += 1, its flag = 1, frame_cnt = HOLD_FRAMES, -> HOLD.
- PLAY, point0 and point1 events in the same cycle: both ignored, no count change.
- PLAY, start event: counts cleared, stay in PLAY.
- HOLD, point events: ignored. Events that occur during HOLD are lost, not queued.
- HOLD, each frame event: frame_cnt -= 1.
- HOLD exit, on the frame event that makes frame_cnt reach 0:
  - flags cleared;
  - if the scoring player's count == WIN_SCORE: winner set, -> OVER;
  - otherwise -> PLAY.
- HOLD, start event: counts and flags cleared, -> PLAY. Start takes priority over a frame event in the same cycle.
- OVER: the winner's flag is held at 1, the other flag is 0, game_over = 1. A start event clears counts, winner and flags, -> PLAY.
- Arithmetic: counts saturate at WIN_SCORE and never wrap. frame_cnt is $clog2(HOLD_FRAMES+1) bits wide and never underflows.
- Invariants: score0 and score1 are never high together. At most one FSM transition per cycle.

Optional Feature:
- Macro SCORE_BLINK_EN.
- Defined: during HOLD the active flag toggles on every 8th frame event, starting at 1, giving a blinking display. OVER remains steady.
- Undefined: the flag is steady high for the whole of HOLD.
- Counts, winner and all timing are identical in both builds.

Decomposition:
- Package score_pkg holds:
  - the state enum: IDLE, PLAY, HOLD, OVER;
  - winner encodings: WIN_NONE, WIN_P0, WIN_P1;
  - default WIN_SCORE and HOLD_FRAMES constants.
- One sub-module, sig_edge: a one-bit register with rise and fall outputs. It is instantiated for start, point0, point1 and vsync. The vsync instance resets its register to 1.

Test Plan (WIN_SCORE=3, HOLD_FRAMES=2, vsync low 2 cycles every 20 cycles):
- rst low during HOLD with count0=2 -> all outputs 0 immediately (asynchronously), FSM=IDLE. After release, point0 is ignored until a start event.
- start, then a point0 pulse -> 1 cycle later count0=1, score0=1. score0 falls on the 2nd vsync falling edge; FSM back in PLAY.
- point0 and point1 asserted in the same cycle while in PLAY -> counts unchanged, both flags stay 0.
- point1 pulse during HOLD -> ignored; count1 unchanged after HOLD ends.
- Three point1 wins -> after the 3rd hold: winner=10, game_over=1, score1=1 held. A further point1 leaves count1=3. start -> counts 0, winner 00, PLAY.
- SCORE_BLINK_EN build with HOLD_FRAMES=20 -> score0 toggles every 8 frames during HOLD. Counts and exit timing match the non-blink build.
